instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h0, fetch address loaded on reset; low 2 bits SHALL be zero.
REQ-002 Parameter BUF_DEPTH, 2, instruction buffer entries; SHALL be a power of two, >= 2.
REQ-003 CLOCK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 IMEM_REQ  out  1  fetch request to instruction memory.
REQ-006 IMEM_ADDR  out  64  word-aligned fetch address.
REQ-007 IMEM_ACK  in  1  memory accepted the request; IMEM_RDATA valid in the same cycle.
REQ-008 IMEM_RDATA  in  32  fetched instruction word.
REQ-009 INSTR_VALID  out  1  buffer head holds a valid instruction for decode.
REQ-010 INSTRUCTION  out  32  buffer-head instruction word.
REQ-011 INSTR_PC  out  64  address of the buffer-head instruction.
REQ-012 nextnextPC  out  64  INSTR_PC + 4, modulo 2^64.
REQ-013 DECODE_READY  in  1  decode consumes the head this cycle when INSTR_VALID is high.
REQ-014 JUMP  in  1  redirect pulse from control.
REQ-015 JUMP_TARGET  in  64  redirect address; bits [1:0] SHALL be ignored (treated as 0).

Function
REQ-016 Fetch PC register FPC SHALL drive IMEM_ADDR; IMEM_REQ SHALL be high only when (buffer count + outstanding) < BUF_DEPTH, and at most one request SHALL be outstanding.
REQ-017 Once IMEM_REQ is raised, IMEM_REQ and IMEM_ADDR SHALL stay stable until the cycle IMEM_ACK is sampled high, including across a JUMP.
REQ-018 On IMEM_ACK with no pending drop: {IMEM_RDATA, IMEM_ADDR} SHALL be pushed into the buffer and FPC SHALL advance by 4, wrapping 64'hFFFF_FFFF_FFFF_FFFC -> 0.
REQ-019 With a zero-wait memory (ACK in the REQ cycle), the instruction SHALL appear at INSTR_VALID in the following cycle; sustained throughput SHALL be one instruction per cycle.
REQ-020 Handshake with decode: the head SHALL be popped when INSTR_VALID & DECODE_READY; outputs SHALL hold unchanged while INSTR_VALID & !DECODE_READY.
REQ-021 Simultaneous push and pop SHALL keep count unchanged; push into a full buffer SHALL not occur (guaranteed by REQ-016).
REQ-022 JUMP high: buffer SHALL be flushed (INSTR_VALID low next cycle), FPC SHALL load {JUMP_TARGET[63:2],2'b00}; if a request is outstanding and not acked this cycle, a drop flag SHALL be set.
REQ-023 An ACK while the drop flag is set, or in the same cycle as JUMP, SHALL be discarded without advancing FPC; the drop flag clears on that ACK.
REQ-024 The first request to the jump target SHALL be issued in the cycle after the outstanding request (if any) completes.
REQ-025 JUMP and a decode pop in the same cycle: flush SHALL take priority; the pop has no further effect.

Reset
REQ-026 While RESET is high: FPC = RESET_PC, buffer empty, drop flag and outstanding cleared, IMEM_REQ = 0, INSTR_VALID = 0, INSTRUCTION = 0, INSTR_PC = 0, nextnextPC = 0.
REQ-027 IMEM_ACK during reset SHALL be ignored; reset mid-request SHALL abandon it; first IMEM_REQ SHALL assert in the first cycle after RESET falls.

Configuration
REQ-028 Macro FETCH_STALL_CNT_EN defined: output STALL_CNT (32 bits) SHALL count cycles with DECODE_READY high and INSTR_VALID low, saturate at 32'hFFFF_FFFF, reset to 0.
REQ-029 Macro undefined: STALL_CNT port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold INSTR_W = 32, ADDR_W = 64, PC_STEP = 4 and the buffer-entry struct {instr, pc}.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (synchronous FIFO with push, pop, flush, count, empty, full).

Verification
REQ-032 Reset release, zero-wait memory returning 0x8B020020 at 0: IMEM_ADDR 0,4,8 on consecutive cycles; INSTRUCTION 0x8B020020, INSTR_PC 0, nextnextPC 4 one cycle after first ACK.
REQ-033 DECODE_READY held low 5 cycles: buffer fills to 2, IMEM_REQ drops, outputs stable; on READY, resumes at 1 instr/cycle with no loss or duplicate.
REQ-034 JUMP to 0x103 with request at 0x10 outstanding, ACK 3 cycles later: 0x10 data discarded, next IMEM_ADDR = 0x100, INSTR_VALID low until 0x100 arrives.
REQ-035 JUMP and ACK in same cycle: ACK data dropped, FPC = target, no drop flag left set.
REQ-036 RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC: second fetch address = 0; RESET asserted mid-request: IMEM_REQ low next cycle, refetch from RESET_PC.
REQ-037 FETCH_STALL_CNT_EN build: 7 cycles READY high with empty buffer -> STALL_CNT = 7; preset near max -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared widths, PC step and buffer-entry type for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: push/pop/flush with occupancy count, empty and full flags.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a decode buffer, with jump redirect.
// Optional FETCH_STALL_CNT_EN adds STALL_CNT, a saturating count of decode-starved cycles.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTRUCTION,
    output logic [63:0] INSTR_PC,
    output logic [63:0] nextnextPC,
    input  logic        DECODE_READY,
    input  logic        JUMP,
    input  logic [63:0] JUMP_TARGET
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] STALL_CNT
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_outstanding;
    logic              r_drop;
    logic              w_ack;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;

    // A raised request is held (with its original address) until acked, even if FPC is redirected.
    assign IMEM_REQ  = !RESET && (r_outstanding || (w_count < CNT_W'(BUF_DEPTH)));
    assign IMEM_ADDR = r_outstanding ? r_req_addr : r_fpc;
    assign w_ack     = IMEM_REQ && IMEM_ACK;
    assign w_push    = w_ack && !r_drop && !JUMP && !w_full;
    assign w_pop     = INSTR_VALID && DECODE_READY && !JUMP;
    assign w_entry   = '{instr: IMEM_RDATA, pc: IMEM_ADDR};

    assign INSTR_VALID = !RESET && !w_empty;
    assign INSTRUCTION = INSTR_VALID ? w_head.instr : '0;
    assign INSTR_PC    = INSTR_VALID ? w_head.pc : '0;
    assign nextnextPC  = INSTR_VALID ? pc_next(w_head.pc) : '0;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_fpc         <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_outstanding <= IMEM_REQ && !IMEM_ACK;
            r_req_addr    <= IMEM_ADDR;
            if (JUMP) begin
                r_fpc <= JUMP_TARGET & ~64'h3;
            end else if (w_push) begin
                r_fpc <= pc_next(r_fpc);
            end
            // The in-flight response belongs to the old stream only if the jump leaves it unacked.
            if (JUMP) begin
                r_drop <= IMEM_REQ && !IMEM_ACK;
            end else if (w_ack) begin
                r_drop <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk    (CLOCK),
        .rst    (RESET),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_flush(JUMP),
        .i_data (w_entry),
        .o_data (w_head),
        .o_count(w_count),
        .o_empty(w_empty),
        .o_full (w_full)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (DECODE_READY && !INSTR_VALID && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: program-order stream model, memory responder, protocol monitor.
// With FETCH_STALL_CNT_EN defined the STALL_CNT count is also checked.
module tb_instr_fetch;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        INSTR_VALID;
    logic [31:0] INSTRUCTION;
    logic [63:0] INSTR_PC;
    logic [63:0] nextnextPC;
    logic        DECODE_READY = 1'b0;
    logic        JUMP = 1'b0;
    logic [63:0] JUMP_TARGET = '0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] STALL_CNT;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          mem_mode = 0;   // 0 zero-wait, 1 random wait, 2 ack only when ack_now
    logic        ack_now = 1'b0;
    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] model_pc;
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    logic        pv_hold = 1'b0;
    logic        pv_jump = 1'b0;
    logic [31:0] pv_instr = '0;
    logic [63:0] pv_pc = '0;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .BUF_DEPTH(2)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR_VALID (INSTR_VALID),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_PC    (INSTR_PC),
        .nextnextPC  (nextnextPC),
        .DECODE_READY(DECODE_READY),
        .JUMP        (JUMP),
        .JUMP_TARGET (JUMP_TARGET)
`ifdef FETCH_STALL_CNT_EN
        ,
        .STALL_CNT   (STALL_CNT)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] h;
        if (a == 64'h0) return 32'h8B02_0020;
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return h[63:32] ^ h[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc = model_pc + 64'd4;
        end
    endtask

    task automatic restart(input logic [63:0] pc);
        exp_q.delete();
        model_pc = {pc[63:2], 2'b00};
        topup();
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic jmp, input logic [63:0] tgt);
        @(posedge CLOCK);
        #1;
        RESET        = rst;
        DECODE_READY = rdy;
        JUMP         = jmp;
        JUMP_TARGET  = tgt;
        if (rst) restart(RST_PC);
        else if (jmp) restart(tgt);
        topup();
    endtask

    // Memory responder plus request-stability check.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (!RESET && pend) begin
                chk("req_held", 64'(IMEM_REQ), 64'd1);
                chk("addr_held", IMEM_ADDR, pend_addr);
            end
            if (RESET) begin
                IMEM_ACK = ($urandom_range(0, 1) == 1);
            end else begin
                IMEM_ACK = IMEM_REQ && ((mem_mode == 0) ||
                           (mem_mode == 1 && $urandom_range(0, 2) == 0) ||
                           (mem_mode == 2 && ack_now));
            end
            IMEM_RDATA = (IMEM_ACK && !RESET) ? mem_word(IMEM_ADDR) : $urandom();
            pend       = !RESET && IMEM_REQ && !IMEM_ACK;
            pend_addr  = IMEM_ADDR;
        end
    end

    // Monitor: pops expected stream on each decode handshake.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (RESET) begin
                chk("rst_valid", 64'(INSTR_VALID), 64'd0);
                chk("rst_instr", 64'(INSTRUCTION), 64'd0);
                chk("rst_pc", INSTR_PC, 64'd0);
                chk("rst_npc", nextnextPC, 64'd0);
                chk("rst_req", 64'(IMEM_REQ), 64'd0);
            end else begin
                if (pv_jump) chk("flush_valid", 64'(INSTR_VALID), 64'd0);
                if (pv_hold) begin
                    chk("hold_valid", 64'(INSTR_VALID), 64'd1);
                    chk("hold_instr", 64'(INSTRUCTION), 64'(pv_instr));
                    chk("hold_pc", INSTR_PC, pv_pc);
                end
                if (INSTR_VALID && DECODE_READY && !JUMP) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL sb_empty: got pc %h expected no delivery", INSTR_PC);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", INSTR_PC, e.pc);
                        chk("sb_instr", 64'(INSTRUCTION), 64'(e.instr));
                        chk("sb_npc", nextnextPC, e.pc + 64'd4);
                    end
                end
            end
            pv_jump  = JUMP && !RESET;
            pv_hold  = INSTR_VALID && !DECODE_READY && !JUMP && !RESET;
            pv_instr = INSTRUCTION;
            pv_pc    = INSTR_PC;
        end
    end

    initial begin
        logic [63:0] tgt;
        restart(RST_PC);

`ifdef FETCH_STALL_CNT_EN
        mem_mode = 2;
        repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("stall_cnt", 64'(STALL_CNT), 64'd7);
`endif

        // Reset release with zero-wait memory.
        mem_mode = 0;
        repeat (3) cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("first_req", 64'(IMEM_REQ), 64'd1);
        chk("addr0", IMEM_ADDR, 64'h0);
        chk("valid_before_ack", 64'(INSTR_VALID), 64'd0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("addr4", IMEM_ADDR, 64'h4);
        chk("first_instr", 64'(INSTRUCTION), 64'h8B02_0020);
        chk("first_pc", INSTR_PC, 64'h0);
        chk("first_npc", nextnextPC, 64'h4);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("addr8", IMEM_ADDR, 64'h8);

        // Decode stall: buffer fills, request drops, then resumes.
        repeat (5) cyc(1'b0, 1'b0, 1'b0, '0);
        @(negedge CLOCK);
        chk("full_req_low", 64'(IMEM_REQ), 64'd0);
        chk("full_valid", 64'(INSTR_VALID), 64'd1);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, '0);

        // Jump while a request is outstanding.
        mem_mode = 2;
        repeat (3) cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 64'h10);
        @(negedge CLOCK);
        chk("j1_req_pend", 64'(IMEM_REQ), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        ack_now = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, '0);
        ack_now = 1'b0;
        @(negedge CLOCK);
        chk("addr_0x10", IMEM_ADDR, 64'h10);
        chk("valid_after_j1", 64'(INSTR_VALID), 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 64'h103);
        @(negedge CLOCK);
        chk("addr_stable_jump", IMEM_ADDR, 64'h10);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        ack_now = 1'b1;
        @(negedge CLOCK);
        chk("valid_wait", 64'(INSTR_VALID), 64'd0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        ack_now = 1'b0;
        @(negedge CLOCK);
        chk("addr_0x100", IMEM_ADDR, 64'h100);
        chk("valid_drop", 64'(INSTR_VALID), 64'd0);
        mem_mode = 0;
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("target_pc", INSTR_PC, 64'h100);

        // Jump coincident with an ack.
        cyc(1'b0, 1'b1, 1'b1, 64'h2000);
        @(negedge CLOCK);
        chk("jack_req", 64'(IMEM_REQ), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("jack_addr", IMEM_ADDR, 64'h2000);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("jack_next", IMEM_ADDR, 64'h2004);

        // Address wrap.
        cyc(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("wrap_addr_hi", IMEM_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("wrap_addr_lo", IMEM_ADDR, 64'h0);
        chk("wrap_npc", nextnextPC, 64'h0);

        // Reset in the middle of a request.
        mem_mode = 2;
        repeat (2) cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("rst_mid_req", 64'(IMEM_REQ), 64'd0);
        mem_mode = 0;
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);
        chk("refetch_req", 64'(IMEM_REQ), 64'd1);
        chk("refetch_addr", IMEM_ADDR, RST_PC);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) mem_mode = $urandom_range(0, 1);
            tgt = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 24) == 0, tgt);
        end
        mem_mode = 0;
        repeat (10) cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLOCK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
